core_seq_ctrl: RTL and testbench

Sequencer for the weight-stationary core. It drives the core's 34-bit instruction bus to run one tile:
- load a kernel from activation/weight SRAM into L0, then into the PE array;
- stream cfg_len activation vectors and execute;
- drain the output FIFO into psum SRAM, with optional read-modify-write accumulation.
It sits between the host/testbench and the core, replacing hand-written instruction streams.

---
 rtl/core_seq_ctrl_pkg.sv | 38 +++
 rtl/core_seq_ctrl_if.sv | 31 +++
 rtl/core_seq_ctrl_drain.sv | 82 ++++++++
 rtl/core_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_core_seq_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the weight-stationary core sequencer.
// Holds the sizing constants, the FSM state encoding, the instruction bus
// bit positions and the idle instruction word.
package core_seq_pkg;

  localparam int ROW     = 8;     // PE array rows, kernel vectors per tile
  localparam int COL     = 8;     // PE array columns
  localparam int ADDR_BW = 11;    // SRAM address width
  localparam int LEN_BW  = 11;    // activation-count config width
  localparam int TIMEOUT = 1024;  // idle cycles tolerated in DRAIN
  localparam int CNT_W   = 12;    // covers cfg_len, ROW+COL and TIMEOUT
  localparam int INST_W  = 34;

  typedef enum logic [2:0] {
    IDLE, W_RD, K_LOAD, K_WAIT, A_RD, EXEC, DRAIN, FIN
  } state_e;

  localparam int B_ACC       = 33;
  localparam int B_P_CEN     = 32;
  localparam int B_P_WEN     = 31;
  localparam int B_P_ADDR_LO = 20;
  localparam int B_X_CEN     = 19;
  localparam int B_X_WEN     = 18;
  localparam int B_X_ADDR_LO = 7;
  localparam int B_OFIFO_RD  = 6;
  localparam int B_IFIFO_WR  = 5;
  localparam int B_IFIFO_RD  = 4;
  localparam int B_L0_RD     = 3;
  localparam int B_L0_WR     = 2;
  localparam int B_EXEC      = 1;
  localparam int B_LOAD      = 0;

  // Both SRAMs deselected and not writing, everything else off.
  localparam logic [INST_W-1:0] IDLE_INST =
    (INST_W'(1) << B_P_CEN) | (INST_W'(1) << B_P_WEN) |
    (INST_W'(1) << B_X_CEN) | (INST_W'(1) << B_X_WEN);

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Host/core-facing bundle of the sequencer.
//   start, cfg_*      : tile request and its configuration (host -> sequencer)
//   ofifo_valid       : core output FIFO non-empty (core -> sequencer)
//   inst              : registered 34-bit core instruction bus
//   busy, done, err   : tile status
// master = host side, slave = sequencer side.
interface core_seq_ctrl_if;
  import core_seq_pkg::*;

  logic                start;
  logic [ADDR_BW-1:0]  cfg_w_base;
  logic [ADDR_BW-1:0]  cfg_x_base;
  logic [ADDR_BW-1:0]  cfg_p_base;
  logic [LEN_BW-1:0]   cfg_len;
  logic                cfg_acc;
  logic                ofifo_valid;
  logic [INST_W-1:0]   inst;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, cfg_w_base, cfg_x_base, cfg_p_base, cfg_len, cfg_acc, ofifo_valid,
    input  inst, busy, done, err
  );

  modport slave (
    input  start, cfg_w_base, cfg_x_base, cfg_p_base, cfg_len, cfg_acc, ofifo_valid,
    output inst, busy, done, err
  );
endinterface

// File: rtl/core_seq_ctrl_drain.sv
// Drain engine: moves len output vectors from the output FIFO into psum SRAM.
// Each vector takes a P0 (FIFO read, optional psum read) and a P1 (psum write).
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   go_i               one-cycle kick, starts at vector 0
//   len_i/base_i/acc_i latched tile config
//   ofifo_valid_i      FIFO non-empty
//   fin_o              last cycle of the drain (normal or timeout)
//   timeout_err_o      fin_o caused by the idle timeout
//   inst_hi_o          next-cycle inst[33:20] = {acc, psum CEN, psum WEN, addr}
//   ofifo_rd_o         next-cycle inst[6]
module core_seq_drain
  import core_seq_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               go_i,
  input  logic [LEN_BW-1:0]  len_i,
  input  logic [ADDR_BW-1:0] base_i,
  input  logic               acc_i,
  input  logic               ofifo_valid_i,
  output logic               fin_o,
  output logic               timeout_err_o,
  output logic [13:0]        inst_hi_o,
  output logic               ofifo_rd_o
);

  logic              active_q;
  logic              p1_q;
  logic [LEN_BW-1:0] idx_q;
  logic [CNT_W-1:0]  wait_q;
  logic [ADDR_BW-1:0] addr;

  always_comb begin
    addr          = base_i + idx_q;  // wraps modulo 2^ADDR_BW
    inst_hi_o     = {1'b0, 1'b1, 1'b1, {ADDR_BW{1'b0}}};
    ofifo_rd_o    = 1'b0;
    fin_o         = 1'b0;
    timeout_err_o = 1'b0;
    if (active_q) begin
      if (p1_q) begin
        inst_hi_o = {acc_i, 1'b0, 1'b0, addr};
        fin_o     = (idx_q == len_i - LEN_BW'(1));
      end else if (ofifo_valid_i) begin
        ofifo_rd_o = 1'b1;
        // With accumulation the old psum is read now so the core has it for P1.
        if (acc_i) inst_hi_o = {1'b0, 1'b0, 1'b1, addr};
      end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
        fin_o         = 1'b1;
        timeout_err_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      p1_q     <= 1'b0;
      idx_q    <= '0;
      wait_q   <= '0;
    end else if (go_i) begin
      active_q <= 1'b1;
      p1_q     <= 1'b0;
      idx_q    <= '0;
      wait_q   <= '0;
    end else if (active_q) begin
      if (p1_q) begin
        if (fin_o) active_q <= 1'b0;
        else       idx_q    <= idx_q + LEN_BW'(1);
        p1_q <= 1'b0;
      end else if (ofifo_valid_i) begin
        p1_q   <= 1'b1;
        wait_q <= '0;
      end else if (timeout_err_o) begin
        active_q <= 1'b0;
      end else begin
        wait_q <= wait_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Tile sequencer for the weight-stationary core. Replaces hand-written
// instruction streams: kernel load (xmem -> L0 -> PE array), activation
// stream + execute, then output drain into psum SRAM.
// Ports:
//   clk_i     clock, rising edge
//   reset_ni  asynchronous active-low reset
//   bus       core_seq_ctrl_if.slave: start/cfg_*/ofifo_valid in,
//             inst/busy/done/err out (all outputs registered)
module core_seq_ctrl
  import core_seq_pkg::*;
(
  input logic             clk_i,
  input logic             reset_ni,
  core_seq_ctrl_if.slave  bus
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic               busy_q, done_q, err_q;

  logic [ADDR_BW-1:0] w_base_q, x_base_q, p_base_q;
  logic [LEN_BW-1:0]  len_q;
  logic               acc_q;

  logic [ADDR_BW-1:0] rd_base;
  logic [CNT_W-1:0]   rd_last;
  logic               go;
  logic               drn_fin, drn_tmo, drn_rd;
  logic [13:0]        drn_hi;

  assign go = (state_q == EXEC) && (cnt_q == {1'b0, len_q} - CNT_W'(1));

  core_seq_drain u_drain (
    .clk_i         (clk_i),
    .rst_ni        (reset_ni),
    .go_i          (go),
    .len_i         (len_q),
    .base_i        (p_base_q),
    .acc_i         (acc_q),
    .ofifo_valid_i (bus.ofifo_valid),
    .fin_o         (drn_fin),
    .timeout_err_o (drn_tmo),
    .inst_hi_o     (drn_hi),
    .ofifo_rd_o    (drn_rd)
  );

  // Instruction decode of the current state; registered below, so each state's
  // pattern reaches the bus one cycle after the state is entered.
  always_comb begin
    inst_d  = IDLE_INST;
    rd_base = (state_q == W_RD) ? w_base_q : x_base_q;
    rd_last = (state_q == W_RD) ? CNT_W'(ROW) : {1'b0, len_q};
    case (state_q)
      W_RD, A_RD: begin
        if (cnt_q < rd_last) begin
          inst_d[B_X_CEN] = 1'b0;
          inst_d[B_X_ADDR_LO +: ADDR_BW] = rd_base + cnt_q[ADDR_BW-1:0];
        end
        // SRAM data arrives one cycle after each read; L0 captures it then.
        if (cnt_q != '0) inst_d[B_L0_WR] = 1'b1;
      end
      K_LOAD: begin
        inst_d[B_LOAD]  = 1'b1;
        inst_d[B_L0_RD] = 1'b1;
      end
      EXEC: begin
        inst_d[B_EXEC]  = 1'b1;
        inst_d[B_L0_RD] = 1'b1;
      end
      DRAIN: begin
        inst_d[INST_W-1:B_P_ADDR_LO] = drn_hi;
        inst_d[B_OFIFO_RD]           = drn_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      inst_q <= inst_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= (bus.cfg_len == '0) ? FIN : W_RD;
        end
        W_RD: if (cnt_q == CNT_W'(ROW)) begin
          cnt_q <= '0; state_q <= K_LOAD;
        end else cnt_q <= cnt_q + CNT_W'(1);
        K_LOAD: if (cnt_q == CNT_W'(COL - 1)) begin
          cnt_q <= '0; state_q <= K_WAIT;
        end else cnt_q <= cnt_q + CNT_W'(1);
        K_WAIT: if (cnt_q == CNT_W'(ROW + COL - 1)) begin
          cnt_q <= '0; state_q <= A_RD;
        end else cnt_q <= cnt_q + CNT_W'(1);
        A_RD: if (cnt_q == {1'b0, len_q}) begin
          cnt_q <= '0; state_q <= EXEC;
        end else cnt_q <= cnt_q + CNT_W'(1);
        EXEC: if (go) begin
          cnt_q <= '0; state_q <= DRAIN;
        end else cnt_q <= cnt_q + CNT_W'(1);
        DRAIN: if (drn_fin) begin
          state_q <= FIN;
          if (drn_tmo) err_q <= 1'b1;
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Config is captured only on an accepted start; later cfg changes are ignored.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && bus.start) begin
      w_base_q <= bus.cfg_w_base;
      x_base_q <= bus.cfg_x_base;
      p_base_q <= bus.cfg_p_base;
      len_q    <= bus.cfg_len;
      acc_q    <= bus.cfg_acc;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  logic clk_i = 1'b0;
  logic reset_ni;
  always #5 clk_i = ~clk_i;

  core_seq_ctrl_if bus();

  core_seq_ctrl dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  typedef struct packed {
    logic        wen;
    logic [10:0] addr;
    logic        acc;
  } pev_t;

  int   total = 0;
  int   bad   = 0;
  int   xq[$];
  pev_t pq[$];
  bit   mon_en = 1'b0;
  int   vmode  = 0;
  int   vcnt   = 0;
  int   n_load, n_exec, n_l0rd, n_ofrd;
  bit   prev_xrd, prev_vld, prev_prd, cur_acc;
  logic [10:0] prev_paddr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ofifo_valid source: 0 = held 1, 1 = 1,0,0 repeating, 2 = stuck 0, 3 = random
  always @(posedge clk_i) begin
    #1;
    case (vmode)
      0: bus.ofifo_valid = 1'b1;
      1: begin bus.ofifo_valid = (vcnt % 3 == 0); vcnt++; end
      2: bus.ofifo_valid = 1'b0;
      default: bus.ofifo_valid = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard for every memory access seen on inst.
  always @(negedge clk_i) begin : mon
    logic [33:0] w;
    pev_t e;
    if (mon_en) begin
      w = bus.inst;
      if (!w[19]) begin
        chk("xwen", 64'(w[18]), 64'(1));
        chk("xq_nonempty", 64'(xq.size() != 0), 64'(1));
        if (xq.size() != 0) chk("xaddr", 64'(w[17:7]), 64'(xq.pop_front()));
      end
      if (w[2] || prev_xrd) chk("l0wr_lag", 64'(w[2]), 64'(prev_xrd));
      if (!w[32]) begin
        chk("pq_nonempty", 64'(pq.size() != 0), 64'(1));
        if (pq.size() != 0) begin
          e = pq.pop_front();
          chk("psum_ev", 64'({w[31], w[30:20], w[33]}), 64'(e));
        end
        if (cur_acc && !w[31])
          chk("rmw_adj", 64'(prev_prd && (prev_paddr == w[30:20])), 64'(1));
      end
      if (w[6]) begin
        n_ofrd++;
        chk("ofrd_vld", 64'(prev_vld), 64'(1));
      end
      if (w[0]) n_load++;
      if (w[1]) n_exec++;
      if (w[3]) n_l0rd++;
      prev_xrd   = !w[19];
      prev_prd   = !w[32] && w[31];
      prev_paddr = w[30:20];
      prev_vld   = bus.ofifo_valid;
    end
  end

  task automatic run_tile(input int wb, input int xb, input int pb, input int ln,
                          input int ac, input int vm, input int exp_lat, input bit extra);
    int   lat;
    bit   got;
    pev_t e;
    xq.delete();
    pq.delete();
    if (ln > 0) begin
      for (int i = 0; i < 8; i++)  xq.push_back((wb + i) % 2048);
      for (int i = 0; i < ln; i++) xq.push_back((xb + i) % 2048);
    end
    if (vm != 2) begin
      for (int k = 0; k < ln; k++) begin
        if (ac != 0) begin
          e.wen = 1'b1; e.addr = 11'((pb + k) % 2048); e.acc = 1'b0;
          pq.push_back(e);
        end
        e.wen = 1'b0; e.addr = 11'((pb + k) % 2048); e.acc = 1'(ac);
        pq.push_back(e);
      end
    end
    n_load = 0; n_exec = 0; n_l0rd = 0; n_ofrd = 0;
    prev_xrd = 0; prev_vld = 0; prev_prd = 0; prev_paddr = '0;
    cur_acc = (ac != 0);
    vmode = vm;
    vcnt  = 0;
    @(posedge clk_i); #1;
    bus.cfg_w_base = 11'(wb);
    bus.cfg_x_base = 11'(xb);
    bus.cfg_p_base = 11'(pb);
    bus.cfg_len    = 11'(ln);
    bus.cfg_acc    = 1'(ac);
    bus.start      = 1'b1;
    mon_en         = 1'b1;
    @(posedge clk_i); #1;
    bus.start = 1'b0;
    got = 1'b0;
    for (lat = 1; lat < 5000; lat++) begin
      @(negedge clk_i);
      if (lat == 1) begin
        chk("busy_on", 64'(bus.busy), 64'(1));
        chk("err_clr", 64'(bus.err), 64'(0));
      end
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (extra) begin
        bus.start      = (lat == 3 || lat == 10 || lat == 30);
        bus.cfg_len    = 11'($urandom);
        bus.cfg_p_base = 11'($urandom);
        bus.cfg_acc    = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    chk("done_seen", 64'(got), 64'(1));
    if (exp_lat >= 0) chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_at_done", 64'(bus.busy), 64'(0));
    chk("err_at_done", 64'(bus.err), 64'(vm == 2));
    chk("xq_left", 64'(xq.size()), 64'(0));
    chk("pq_left", 64'(pq.size()), 64'(0));
    chk("n_load", 64'(n_load), 64'(ln > 0 ? 8 : 0));
    chk("n_exec", 64'(n_exec), 64'(ln));
    chk("n_l0rd", 64'(n_l0rd), 64'(ln > 0 ? 8 + ln : 0));
    chk("n_ofrd", 64'(n_ofrd), 64'(vm == 2 ? 0 : ln));
    @(negedge clk_i);
    chk("done_pulse", 64'(bus.done), 64'(0));
    repeat (20) @(negedge clk_i);
    chk("busy_after", 64'(bus.busy), 64'(0));
    chk("err_hold", 64'(bus.err), 64'(vm == 2));
    chk("inst_after", 64'(bus.inst), 64'(IDLE_W));
    mon_en = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0;
    bus.start = 1'b0;
    bus.cfg_w_base = '0; bus.cfg_x_base = '0; bus.cfg_p_base = '0;
    bus.cfg_len = '0; bus.cfg_acc = 1'b0; bus.ofifo_valid = 1'b0;
    vmode = 3;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      bus.start      = 1'($urandom);
      bus.cfg_len    = 11'($urandom);
      bus.cfg_w_base = 11'($urandom);
      bus.cfg_acc    = 1'($urandom);
      chk("rst_inst", 64'(bus.inst), 64'(IDLE_W));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_err",  64'(bus.err),  64'(0));
    end
    bus.start = 1'b0;
    vmode = 0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    run_tile(0, 0, 0, 0, 0, 0, 2, 1'b0);          // empty tile
    run_tile(0, 16, 100, 4, 0, 0, 52, 1'b0);      // plain tile
    run_tile(0, 16, 100, 4, 1, 1, -1, 1'b0);      // accumulate, gappy FIFO
    run_tile(3, 40, 200, 2, 0, 2, 1064, 1'b0);    // drain timeout
    run_tile(5, 2045, 2046, 4, 0, 0, 52, 1'b1);   // address wrap + ignored starts

    // Reset in the middle of EXEC
    vmode = 0;
    @(posedge clk_i); #1;
    bus.cfg_w_base = 11'd0; bus.cfg_x_base = 11'd64; bus.cfg_p_base = 11'd0;
    bus.cfg_len = 11'd20; bus.cfg_acc = 1'b0; bus.start = 1'b1;
    @(posedge clk_i); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 200 && !bus.inst[1]; i++) @(negedge clk_i);
    chk("exec_seen", 64'(bus.inst[1]), 64'(1));
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_inst", 64'(bus.inst), 64'(IDLE_W));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_done", 64'(bus.done), 64'(0));
    chk("mid_rst_err",  64'(bus.err),  64'(0));
    @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("post_rst_inst", 64'(bus.inst), 64'(IDLE_W));
    chk("post_rst_busy", 64'(bus.busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
